// File: rtl/z80_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_responder
// Purpose  : Memory/IO target for the tv80s external bus with programmable
//            wait states, interrupt vector supply and a backdoor RAM load port.
//            Optional macro Z80_BUS_ROM_PROTECT_EN makes addresses below
//            ROM_TOP read-only to the CPU and flags attempted writes.
// Revision : 1.0 - initial release
// ============================================================================
module z80_bus_responder #(
    parameter int          ADDR_W     = 16,
    parameter int          MEM_WAIT   = 0,
    parameter int          IO_WAIT    = 1,
    parameter logic [7:0]  INT_VECTOR = 8'hFF,
    parameter logic [15:0] ROM_TOP    = 16'h0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    input  logic [7:0]  io_in,
    output logic        io_wr_stb,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic        ld_we,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        wp_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [2:0] c_K_NONE = 3'd0;
    localparam logic [2:0] c_K_INTA = 3'd1;
    localparam logic [2:0] c_K_REFR = 3'd2;
    localparam logic [2:0] c_K_MRD  = 3'd3;
    localparam logic [2:0] c_K_MWR  = 3'd4;
    localparam logic [2:0] c_K_IORD = 3'd5;
    localparam logic [2:0] c_K_IOWR = 3'd6;

    localparam logic [3:0] c_MEM_N = 4'(MEM_WAIT);
    localparam logic [3:0] c_IO_N  = 4'(IO_WAIT);

    logic [7:0]        r_mem [0:(2**ADDR_W)-1];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              r_wait_n;
    logic              w_wait_n_nxt;
    logic [2:0]        r_kind;
    logic [2:0]        w_kind_nxt;
    logic [2:0]        w_class;
    logic [3:0]        w_class_wait;
    logic              w_bus_idle;
    logic              w_wp_hit;
    logic              w_mem_commit;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [7:0]        r_cpu_di;
    logic              r_io_wr_stb;
    logic [7:0]        r_io_addr;
    logic [7:0]        r_io_wdata;

    assign w_addr     = A[ADDR_W-1:0];
    assign w_ld_addr  = ld_addr[ADDR_W-1:0];
    assign w_bus_idle = mreq_n & iorq_n & rd_n & wr_n;

    // Priority order matters: INTA before refresh, refresh before memory read.
    always_comb begin
        w_class = c_K_NONE;
        if (!m1_n && !iorq_n)        w_class = c_K_INTA;
        else if (!mreq_n && !rfsh_n) w_class = c_K_REFR;
        else if (!mreq_n && !rd_n)   w_class = c_K_MRD;
        else if (!mreq_n && !wr_n)   w_class = c_K_MWR;
        else if (!iorq_n && !rd_n)   w_class = c_K_IORD;
        else if (!iorq_n && !wr_n)   w_class = c_K_IOWR;
    end

    always_comb begin
        w_class_wait = 4'd0;
        case (w_class)
            c_K_MRD, c_K_MWR:   w_class_wait = c_MEM_N;
            c_K_IORD, c_K_IOWR: w_class_wait = c_IO_N;
            default:            w_class_wait = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_wait_n <= 1'b1;
            r_kind   <= c_K_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wait_n <= w_wait_n_nxt;
            r_kind   <= w_kind_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wait_n_nxt = r_wait_n;
        w_kind_nxt   = r_kind;
        case (r_state)
            ST_IDLE: begin
                w_kind_nxt = w_class;
                if (w_class != c_K_NONE && w_class != c_K_REFR) begin
                    if (w_class_wait != 4'd0) begin
                        w_state_nxt  = ST_WAIT;
                        w_cnt_nxt    = w_class_wait;
                        w_wait_n_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (w_bus_idle) begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = 4'd0;
                    w_wait_n_nxt = 1'b1;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt  = ST_ACCESS;
                    w_cnt_nxt    = 4'd0;
                    w_wait_n_nxt = 1'b1;
                end else begin
                    w_cnt_nxt    = r_cnt - 4'd1;
                end
            end
            ST_ACCESS: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                // Leaving on rfsh_n lets the M1 refresh phase be seen as a new cycle.
                if (w_bus_idle || !rfsh_n) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef Z80_BUS_ROM_PROTECT_EN
    logic [15:0] w_addr16;
    logic        r_wp_err;

    always_comb begin
        w_addr16             = 16'd0;
        w_addr16[ADDR_W-1:0] = w_addr;
    end

    assign w_wp_hit = (w_addr16 < ROM_TOP);

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_wp_err <= 1'b0;
        else if (r_state == ST_ACCESS && r_kind == c_K_MWR && w_wp_hit)
            r_wp_err <= 1'b1;
    end

    assign wp_err = r_wp_err;
`else
    logic w_unused_rom;

    assign w_unused_rom = |ROM_TOP;
    assign w_wp_hit     = 1'b0;
    assign wp_err       = 1'b0;
`endif

    // reset_n gates the commit so a reset mid-cycle drops the pending write.
    assign w_mem_commit = reset_n && (r_state == ST_ACCESS) &&
                          (r_kind == c_K_MWR) && !w_wp_hit;

    // Backdoor write is issued last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (w_mem_commit)
            r_mem[w_addr] <= cpu_dout;
        if (ld_we)
            r_mem[w_ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cpu_di    <= 8'hFF;
            r_io_wr_stb <= 1'b0;
            r_io_addr   <= 8'd0;
            r_io_wdata  <= 8'd0;
        end else begin
            r_io_wr_stb <= 1'b0;
            if (r_state == ST_IDLE && (w_class == c_K_IORD || w_class == c_K_IOWR))
                r_io_addr <= A[7:0];
            if (r_state == ST_ACCESS) begin
                case (r_kind)
                    c_K_MRD:  r_cpu_di <= r_mem[w_addr];
                    c_K_IORD: r_cpu_di <= io_in;
                    c_K_IOWR: begin
                        r_io_wr_stb <= 1'b1;
                        r_io_wdata  <= cpu_dout;
                    end
                    c_K_INTA: r_cpu_di <= INT_VECTOR;
                    default:  ;
                endcase
            end else if (r_state == ST_HOLD && r_kind == c_K_MRD && w_state_nxt == ST_HOLD) begin
                r_cpu_di <= r_mem[w_addr];
            end
        end
    end

    assign cpu_di    = r_cpu_di;
    assign wait_n    = r_wait_n;
    assign io_wr_stb = r_io_wr_stb;
    assign io_addr   = r_io_addr;
    assign io_wdata  = r_io_wdata;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80_bus_responder
// Purpose  : Directed scoreboard bench driving two responders (zero-wait and
//            three-wait memory) from one emulated tv80s bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z80_bus_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [15:0] A, ld_addr;
    logic [7:0]  cpu_dout, io_in, ld_data;
    logic        ld_we;
    logic [7:0]  di0, di1, ioa0, ioa1, iow0, iow1;
    logic        wn0, wn1, stb0, stb1, wp0, wp1;

    int checks = 0;
    int errors = 0;
    int wl0, wl1, st0, st1;

`ifdef Z80_BUS_ROM_PROTECT_EN
    localparam logic c_PROT = 1'b1;
`else
    localparam logic c_PROT = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;
    sb_t sb[$];

    z80_bus_responder #(
        .ADDR_W(16), .MEM_WAIT(0), .IO_WAIT(1), .INT_VECTOR(8'hA5), .ROM_TOP(16'h0100)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout),
        .cpu_di(di0), .wait_n(wn0), .io_in(io_in), .io_wr_stb(stb0), .io_addr(ioa0),
        .io_wdata(iow0), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .wp_err(wp0)
    );

    z80_bus_responder #(
        .ADDR_W(15), .MEM_WAIT(3), .IO_WAIT(2), .INT_VECTOR(8'hFF), .ROM_TOP(16'h0100)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout),
        .cpu_di(di1), .wait_n(wn1), .io_in(io_in), .io_wr_stb(stb1), .io_addr(ioa1),
        .io_wdata(iow1), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .wp_err(wp1)
    );

    function automatic void push(input string tag, input logic [15:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endfunction

    task automatic check(input logic [15:0] obs);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0h expected nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!wn0)  wl0++;
        if (!wn1)  wl1++;
        if (stb0)  st0++;
        if (stb1)  st1++;
    endtask

    task automatic clr();
        wl0 = 0; wl1 = 0; st0 = 0; st1 = 0;
    endtask

    task automatic idle_bus();
        @(negedge clk);
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic load(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic mem_read(input logic [15:0] addr, input logic m1, input logic [7:0] e0,
                            input logic [7:0] e1, input logic chk0, input logic rfsh_tail);
        clr();
        if (chk0) begin
            push("mrd_latency_u0", {8'h00, e0});
            push("mrd_wait_u0", 16'd0);
        end
        push("mrd_data_u1", {8'h00, e1});
        push("mrd_wait_u1", 16'd3);
        if (rfsh_tail) begin
            push("rfsh_di_u0", {8'h00, e0});
            push("rfsh_di_u1", {8'h00, e1});
        end
        @(negedge clk);
        A = addr; m1_n = ~m1; mreq_n = 1'b0; rd_n = 1'b0;
        tick(); tick();
        if (chk0) check({8'h00, di0});
        repeat (6) tick();
        if (chk0) check(16'(wl0));
        check({8'h00, di1});
        check(16'(wl1));
        if (rfsh_tail) begin
            // Refresh follows the fetch directly, as on a real M1 cycle.
            @(negedge clk);
            m1_n = 1'b1; rd_n = 1'b1; rfsh_n = 1'b0; A = 16'h0050;
            repeat (3) tick();
            check({8'h00, di0});
            check({8'h00, di1});
        end
        idle_bus();
        tick(); tick();
    endtask

    task automatic mem_write(input logic [15:0] addr, input logic [7:0] data);
        clr();
        push("mwr_wait_u0", 16'd0);
        push("mwr_wait_u1", 16'd3);
        @(negedge clk);
        A = addr; cpu_dout = data; mreq_n = 1'b0; wr_n = 1'b0;
        repeat (6) tick();
        // Data changes while wr_n stays low; a second commit would store it.
        @(negedge clk);
        cpu_dout = ~data;
        repeat (4) tick();
        check(16'(wl0));
        check(16'(wl1));
        idle_bus();
        tick(); tick();
    endtask

    initial begin
        reset_n = 1'b0;
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
        A = 16'h0000; cpu_dout = 8'h00; io_in = 8'h00;
        ld_we = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
        clr();

        push("rst_di_u0", 16'h00FF);   push("rst_wait_u0", 16'd1);
        push("rst_stb_u0", 16'd0);     push("rst_ioaddr_u0", 16'h0000);
        push("rst_iowdata_u0", 16'h0000); push("rst_wp_u0", 16'd0);
        push("rst_di_u1", 16'h00FF);   push("rst_wait_u1", 16'd1);
        repeat (3) tick();
        check({8'h00, di0}); check({15'd0, wn0}); check({15'd0, stb0});
        check({8'h00, ioa0}); check({8'h00, iow0}); check({15'd0, wp0});
        check({8'h00, di1}); check({15'd0, wn1});

        @(negedge clk);
        reset_n = 1'b1;
        load(16'h0000, 8'hCB); load(16'h0001, 8'h6A); load(16'h4E09, 8'hD5);
        load(16'h1234, 8'h5A); load(16'h0050, 8'hEE); load(16'h3000, 8'h12);
        load(16'h0080, 8'h00); load(16'h0100, 8'h00);

        // BIT 5,D sequence: two opcode fetches each followed by refresh
        mem_read(16'h0000, 1'b1, 8'hCB, 8'hCB, 1'b1, 1'b1);
        mem_read(16'h0001, 1'b1, 8'h6A, 8'h6A, 1'b1, 1'b1);
        mem_read(16'h4E09, 1'b0, 8'hD5, 8'hD5, 1'b1, 1'b0);
        mem_read(16'h1234, 1'b0, 8'h5A, 8'h5A, 1'b1, 1'b0);
        // u1 has 15 address bits, so 9234 aliases 1234
        mem_read(16'h9234, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0);

        mem_write(16'h2000, 8'h77);
        mem_read(16'h2000, 1'b0, 8'h77, 8'h77, 1'b1, 1'b0);

        // IO write then IO read
        clr();
        push("iowr_pulses_u0", 16'd1); push("iowr_pulses_u1", 16'd1);
        push("iowr_addr_u0", 16'h0042); push("iowr_data_u0", 16'h0099);
        push("iowr_addr_u1", 16'h0042); push("iowr_data_u1", 16'h0099);
        push("iowr_wait_u0", 16'd1); push("iowr_wait_u1", 16'd2);
        @(negedge clk);
        A = 16'h1142; cpu_dout = 8'h99; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (8) tick();
        check(16'(st0)); check(16'(st1));
        check({8'h00, ioa0}); check({8'h00, iow0});
        check({8'h00, ioa1}); check({8'h00, iow1});
        check(16'(wl0)); check(16'(wl1));
        idle_bus(); tick(); tick();

        clr();
        push("iord_data_u0", 16'h003C); push("iord_data_u1", 16'h003C);
        push("iord_addr_u0", 16'h0043);
        push("iord_wait_u0", 16'd1); push("iord_wait_u1", 16'd2);
        push("iord_nostb_u0", 16'd0);
        @(negedge clk);
        A = 16'h2243; io_in = 8'h3C; iorq_n = 1'b0; rd_n = 1'b0;
        repeat (8) tick();
        check({8'h00, di0}); check({8'h00, di1}); check({8'h00, ioa0});
        check(16'(wl0)); check(16'(wl1)); check(16'(st0));
        idle_bus(); tick(); tick();

        // Interrupt acknowledge
        clr();
        push("inta_vec_u0", 16'h00A5); push("inta_vec_u1", 16'h00FF);
        push("inta_wait_u0", 16'd0);
        @(negedge clk);
        A = 16'h0000; m1_n = 1'b0; iorq_n = 1'b0;
        tick(); tick();
        check({8'h00, di0});
        tick(); tick();
        check({8'h00, di1});
        check(16'(wl0));
        idle_bus(); tick(); tick();

        // Reset asserted while u1 is inserting wait states on a write
        clr();
        push("wait_entry_u1", 16'd0);
        push("rstwait_wait_u1", 16'd1); push("rstwait_di_u1", 16'h00FF);
        push("rstwait_di_u0", 16'h00FF);
        @(negedge clk);
        A = 16'h3000; cpu_dout = 8'h44; mreq_n = 1'b0; wr_n = 1'b0;
        tick();
        check({15'd0, wn1});
        @(negedge clk);
        reset_n = 1'b0;
        tick();
        check({15'd0, wn1}); check({8'h00, di1}); check({8'h00, di0});
        @(negedge clk);
        mreq_n = 1'b1; wr_n = 1'b1; reset_n = 1'b1;
        tick(); tick();
        mem_read(16'h3000, 1'b0, 8'h12, 8'h12, 1'b1, 1'b0);

        // Backdoor collides with u0's commit; u1 commits later and keeps CPU data
        clr();
        @(negedge clk);
        A = 16'h4000; cpu_dout = 8'hAA; mreq_n = 1'b0; wr_n = 1'b0;
        tick();
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 16'h4000; ld_data = 8'hBB;
        tick();
        @(negedge clk);
        ld_we = 1'b0;
        repeat (6) tick();
        idle_bus(); tick(); tick();
        mem_read(16'h4000, 1'b0, 8'hBB, 8'hAA, 1'b1, 1'b0);

        // Write-protect window
        mem_write(16'h0080, 8'h11);
        if (c_PROT) mem_read(16'h0080, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        else        mem_read(16'h0080, 1'b0, 8'h11, 8'h11, 1'b1, 1'b0);
        push("wp_flag_u0", {15'd0, c_PROT}); push("wp_flag_u1", {15'd0, c_PROT});
        check({15'd0, wp0}); check({15'd0, wp1});
        mem_write(16'h0100, 8'h22);
        mem_read(16'h0100, 1'b0, 8'h22, 8'h22, 1'b1, 1'b0);
        load(16'h0080, 8'h33);
        mem_read(16'h0080, 1'b0, 8'h33, 8'h33, 1'b1, 1'b0);
        push("wp_sticky_u0", {15'd0, c_PROT});
        check({15'd0, wp0});

        push("wp_clear_u0", 16'd0); push("wp_clear_u1", 16'd0);
        @(negedge clk);
        reset_n = 1'b0;
        tick();
        check({15'd0, wp0}); check({15'd0, wp1});
        @(negedge clk);
        reset_n = 1'b1;

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Synthesizable memory/IO target sitting on the tv80s external bus, driving the CPU's di and wait_n from the CPU's m1_n/mreq_n/iorq_n/rd_n/wr_n/rfsh_n/A/dout.
- Replaces the behavioural memory and IO arrays in CPU benches and small SoC builds, with programmable wait-state insertion and interrupt-acknowledge vector supply.
- Backdoor load port lets a bench or boot loader preload RAM without CPU cycles.

Parameters:
- ADDR_W, 16: RAM address bits; RAM depth 2**ADDR_W; A[ADDR_W-1:0] used, upper bits alias.
- MEM_WAIT, 0: extra wait cycles (0..15) inserted on every memory read/write.
- IO_WAIT, 1: extra wait cycles (0..15) on IO read/write, on top of the CPU's automatic IO wait.
- INT_VECTOR, 8'hFF: byte returned during interrupt acknowledge (m1_n=0, iorq_n=0).
- ROM_TOP, 16'h0100: first writable address when the optional feature is compiled in.

Ports:
- clk  in  1  single clock, same clock as tv80s.
- reset_n  in  1  synchronous, active-low reset.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU bus strobes, active-low.
- A  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_di  out  8  read data to CPU.
- wait_n  out  1  active-low wait request to CPU.
- io_in  in  8  external IO read data, sampled for any IO read.
- io_wr_stb  out  1  one-cycle pulse per IO write.
- io_addr  out  8  A[7:0] latched at IO cycle start.
- io_wdata  out  8  cpu_dout latched at IO write commit.
- ld_we  in  1  backdoor RAM write enable.
- ld_addr  in  16  backdoor address.
- ld_data  in  8  backdoor data.
- wp_err  out  1  sticky write-protect violation flag.

Behaviour:
- Reset (reset_n=0 at posedge clk): state IDLE, cpu_di=8'hFF, wait_n=1, io_wr_stb=0, io_addr=0, io_wdata=0, wp_err=0, wait counter=0. RAM contents are not cleared. Reset mid-cycle abandons any pending write with no commit.
- Cycle classification, evaluated in IDLE at each posedge, first match wins:
  - INTA: m1_n=0 & iorq_n=0.
  - REFRESH: mreq_n=0 & rfsh_n=0. Ignored: no wait, no write, cpu_di unchanged.
  - MRD: mreq_n=0 & rd_n=0.
  - MWR: mreq_n=0 & wr_n=0.
  - IORD: iorq_n=0 & rd_n=0.
  - IOWR: iorq_n=0 & wr_n=0.
- FSM states and transitions:
  - IDLE -> WAIT when the classified cycle has N>0, where N=MEM_WAIT for MRD/MWR, N=IO_WAIT for IORD/IOWR, N=0 for INTA. Otherwise IDLE -> ACCESS.
  - WAIT: wait_n=0 for exactly N cycles, counter decrements; wait_n=0 is registered in the same cycle the FSM enters WAIT. At count 1 -> ACCESS.
  - ACCESS (one cycle):
    - MRD: cpu_di <= RAM[A].
    - MWR: RAM[A] <= cpu_dout.
    - IORD: cpu_di <= io_in.
    - IOWR: io_wr_stb=1, io_wdata <= cpu_dout.
    - INTA: cpu_di <= INT_VECTOR.
    - Always -> HOLD.
  - HOLD: cpu_di continues tracking RAM[A] for MRD. Exactly one commit per bus cycle, even if wr_n is held for many clocks. Returns to IDLE when all of mreq_n, iorq_n, rd_n, wr_n are 1, or when rfsh_n falls (M1 refresh phase). Strobes going inactive during WAIT -> IDLE, no commit.
- Latency: zero-wait MRD gives data valid one clock after strobes are seen.
- Backdoor load: ld_we writes RAM[ld_addr] at posedge, independent of FSM. If it collides with a CPU MWR commit to the same address, ld_we wins.
- Address width: A and ld_addr are truncated to ADDR_W bits.

Optional Feature:
- Z80_BUS_ROM_PROTECT_EN defined: CPU MWR to addresses below ROM_TOP is dropped (RAM unchanged) and sets wp_err=1, held until reset. Backdoor writes are never blocked.
- Not defined: all addresses writable; wp_err tied 0.

Test Plan:
- Preload 0000=CB, 0001=6A, 4E09=D5; HL=4E09, run BIT 5,D -> CPU reaches PC=0002, R=02; cpu_di returned CB then 6A on the two M1 fetches; wait_n stays 1 throughout (MEM_WAIT=0).
- MEM_WAIT=3: LD A,(1234h) with 1234=5A -> wait_n low exactly 3 clocks per memory cycle; A=5A at end; instruction time grows by 3 clocks per M-cycle.
- LD (2000h),A with A=77 while wr_n is held 3 clocks -> RAM[2000]=77, exactly one commit; REFRESH cycles at addresses 00xx cause no write.
- OUT (42h),A with A=99; then IN A,(43h) with io_in=3C -> one io_wr_stb pulse with io_addr=42, io_wdata=99; A=3C; wait_n low IO_WAIT=1 clock in each IO cycle.
- Force m1_n=0, iorq_n=0 -> cpu_di=FF next clock. Assert reset_n=0 during a WAIT state -> wait_n=1, cpu_di=FF, target RAM byte unchanged.
- With Z80_BUS_ROM_PROTECT_EN: CPU write of 11 to 0080 -> RAM[0080] unchanged, wp_err=1; CPU write to 0100 succeeds; ld_we write to 0080 succeeds.
